// File: rtl/debug_uart_arbiter.sv
// Debug UART arbiter: shares one uart_tx between buffered CPU writes and a
// valid/ready trace byte source, using round-robin grant and a send FSM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate; on grant pop FIFO or ack trace, latch the byte
// SEND    | uart_tx_en high for this single cycle
// WAIT_HI | wait for uart_tx_busy to rise; give up after BUSY_TIMEOUT
// WAIT_LO | wait for uart_tx_busy to fall, then back to IDLE
module debug_uart_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_data,
  input  logic       trace_valid,
  input  logic [7:0] trace_data,
  output logic       trace_ready,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       arb_busy,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [CW-1:0] r_tmo_cnt;
  logic [CW-1:0] w_tmo_cnt_nxt;
  logic          r_last_trace;
  logic          w_last_trace_nxt;
  logic [7:0]    r_tx_data;
  logic [7:0]    w_tx_data_nxt;
  logic          r_tx_en;
  logic          r_overflow;

  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_grant_cpu;
  logic          w_grant_trace;

  assign fifo_empty   = (r_count == '0);
  assign fifo_full    = (r_count == (AW + 1)'(FIFO_DEPTH));
  // A full FIFO still accepts a write when the arbiter pops in the same cycle.
  assign w_push       = cpu_wr && (!fifo_full || w_pop);
  assign w_drop       = cpu_wr && fifo_full && !w_pop;
  assign w_pop        = w_grant_cpu;
  assign trace_ready  = w_grant_trace;
  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign overflow     = r_overflow;
  assign arb_busy     = !fifo_empty || (r_state != S_IDLE);

  // FIFO storage; pointers guard validity so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cpu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Round-robin grant, only evaluated while IDLE.
  always_comb begin
    w_grant_cpu   = 1'b0;
    w_grant_trace = 1'b0;
    if (r_state == S_IDLE) begin
      if (!fifo_empty && trace_valid) begin
        if (r_last_trace) w_grant_cpu   = 1'b1;
        else              w_grant_trace = 1'b1;
      end else if (!fifo_empty) begin
        w_grant_cpu = 1'b1;
      end else if (trace_valid) begin
        w_grant_trace = 1'b1;
      end
    end
  end

  // Send FSM next-state, byte latch and busy-rise timeout.
  always_comb begin
    w_state_nxt      = r_state;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_last_trace_nxt = r_last_trace;
    w_tx_data_nxt    = r_tx_data;
    case (r_state)
      S_IDLE: begin
        if (w_grant_cpu) begin
          w_tx_data_nxt    = r_mem[r_rd_ptr];
          w_last_trace_nxt = 1'b0;
          w_state_nxt      = S_SEND;
        end else if (w_grant_trace) begin
          w_tx_data_nxt    = trace_data;
          w_last_trace_nxt = 1'b1;
          w_state_nxt      = S_SEND;
        end
      end
      S_SEND: begin
        w_tmo_cnt_nxt = '0;
        w_state_nxt   = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (uart_tx_busy) begin
          w_state_nxt = S_WAIT_LO;
        end else if (r_tmo_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          // uart_tx never acknowledged; the byte is silently abandoned.
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!uart_tx_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM registers; the enable pulse is registered off the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tmo_cnt    <= '0;
      r_last_trace <= 1'b1;
      r_tx_data    <= 8'h00;
      r_tx_en      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_last_trace <= w_last_trace_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_en      <= (w_state_nxt == S_SEND);
    end
  end

endmodule

// File: tb/tb_debug_uart_arbiter.sv
// Bench for debug_uart_arbiter: behavioural uart_tx busy model, trace byte
// source, and a scoreboard of expected bytes checked on each enable pulse.
module tb_debug_uart_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_wr;
  logic [7:0] cpu_data;
  logic       trace_valid;
  logic [7:0] trace_data;
  logic       trace_ready;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy = 1'b0;
  logic       fifo_full;
  logic       fifo_empty;
  logic       arb_busy;
  logic       overflow;
  logic       clr_overflow;

  int errors = 0;
  int checks = 0;
  int n_sent = 0;
  int cyc    = 0;
  int busy_len = 0;
  int rem      = 0;
  logic       tr_hs = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] tq[$];
  int         en_times[$];

  typedef struct {
    bit         cpu_en;
    logic [7:0] cpu_b;
    bit         tr_en;
    logic [7:0] tr_b;
    int         busy;
    int         n_exp;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;

  vec_t vecs[5];

  debug_uart_arbiter #(.FIFO_DEPTH(4), .BUSY_TIMEOUT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_wr       (cpu_wr),
    .cpu_data     (cpu_data),
    .trace_valid  (trace_valid),
    .trace_data   (trace_data),
    .trace_ready  (trace_ready),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .arb_busy     (arb_busy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // uart_tx model: busy rises the cycle after the enable and stays high busy_len cycles
  always @(posedge clk) begin
    if (uart_tx_en && busy_len > 0) begin
      uart_tx_busy <= 1'b1;
      rem          <= busy_len - 1;
    end else if (rem > 0) begin
      uart_tx_busy <= 1'b1;
      rem          <= rem - 1;
    end else begin
      uart_tx_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // trace source: holds the head byte valid until the handshake completes
  initial begin
    trace_valid = 1'b0;
    trace_data  = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (tr_hs && tq.size() > 0) tq.delete(0);
      trace_valid = (tq.size() > 0);
      trace_data  = trace_valid ? tq[0] : 8'h00;
      #1;
      tr_hs = trace_valid && trace_ready;
    end
  end

  // scoreboard: every enable pulse must match the next expected byte
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (uart_tx_en) begin
        n_sent++;
        en_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_en: got data=%02h, expected no pulse (t=%0t)", uart_tx_data, $time);
        end else begin
          exp_b = exp_q.pop_front();
          chk("tx_data", uart_tx_data, exp_b);
        end
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() == 0 && tq.size() == 0 && !trace_valid && !arb_busy) break;
      k++;
      if (k >= budget) begin
        checks++;
        errors++;
        $display("FAIL %s: timeout, got %0d bytes still expected, expected 0", name, exp_q.size());
        exp_q.delete();
        tq.delete();
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected $finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int k;
    bit seen;

    vecs[0] = '{1'b1, 8'h55, 1'b1, 8'hAA, 3, 2, 8'h55, 8'hAA};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h7E, 2, 1, 8'h7E, 8'h00};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 8'h00, 0, 1, 8'h33, 8'h00};
    vecs[3] = '{1'b1, 8'h5A, 1'b1, 8'hC3, 4, 2, 8'hC3, 8'h5A};
    vecs[4] = '{1'b1, 8'h00, 1'b1, 8'hFF, 1, 2, 8'hFF, 8'h00};

    rst = 1'b1;
    cpu_wr = 1'b0;
    cpu_data = 8'h00;
    clr_overflow = 1'b0;

    // reset values
    repeat (2) tick();
    chk("rst_tx_en", uart_tx_en, 1'b0);
    chk("rst_tx_data", uart_tx_data, 8'h00);
    chk("rst_trace_ready", trace_ready, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_fifo_empty", fifo_empty, 1'b1);
    chk("rst_fifo_full", fifo_full, 1'b0);
    chk("rst_arb_busy", arb_busy, 1'b0);
    rst = 1'b0;

    // arbitration table: CPU byte written, trace byte offered one cycle later
    for (int v = 0; v < 5; v++) begin
      busy_len = vecs[v].busy;
      n0 = n_sent;
      tick();
      if (vecs[v].cpu_en) begin
        cpu_wr = 1'b1;
        cpu_data = vecs[v].cpu_b;
      end
      exp_q.push_back(vecs[v].exp0);
      if (vecs[v].n_exp == 2) exp_q.push_back(vecs[v].exp1);
      tick();
      cpu_wr = 1'b0;
      if (vecs[v].tr_en) tq.push_back(vecs[v].tr_b);
      wait_idle(100, $sformatf("vec%0d_idle", v));
      chk($sformatf("vec%0d_count", v), n_sent - n0, vecs[v].n_exp);
    end

    // single CPU byte latency and arb_busy release
    busy_len = 10;
    n0 = n_sent;
    tick();
    cpu_wr = 1'b1;
    cpu_data = 8'h41;
    exp_q.push_back(8'h41);
    tick();
    chk("lat_fifo_empty", fifo_empty, 1'b0);
    chk("lat_en_early", uart_tx_en, 1'b0);
    cpu_wr = 1'b0;
    tick();
    chk("lat_en", uart_tx_en, 1'b1);
    chk("lat_data", uart_tx_data, 8'h41);
    seen = 1'b0;
    for (k = 0; k < 5; k++) begin
      tick();
      if (uart_tx_busy) begin seen = 1'b1; break; end
    end
    chk("lat_busy_rose", seen, 1'b1);
    seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      tick();
      if (!uart_tx_busy) begin seen = 1'b1; break; end
    end
    chk("lat_busy_fell", seen, 1'b1);
    chk("lat_arb_busy_hold", arb_busy, 1'b1);
    tick();
    chk("lat_arb_busy_clr", arb_busy, 1'b0);
    chk("lat_count", n_sent - n0, 1);

    // overflow while transmitting, then full write with simultaneous pop
    busy_len = 12;
    n0 = n_sent;
    tick();
    cpu_wr = 1'b1;
    cpu_data = 8'h10;
    exp_q.push_back(8'h10);
    tick();
    cpu_wr = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      cpu_wr = 1'b1;
      cpu_data = 8'(i + 1);
      if (i < 4) exp_q.push_back(8'(i + 1));
    end
    tick();
    cpu_wr = 1'b0;
    busy_len = 3;
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_full", fifo_full, 1'b1);
    tick();
    chk("ovf_sticky", overflow, 1'b1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    repeat (6) tick();
    chk("pop_full_pre", fifo_full, 1'b1);
    cpu_wr = 1'b1;
    cpu_data = 8'h06;
    exp_q.push_back(8'h06);
    tick();
    cpu_wr = 1'b0;
    chk("pop_full_no_ovf", overflow, 1'b0);
    chk("pop_full_still_full", fifo_full, 1'b1);
    wait_idle(200, "ovf_idle");
    chk("ovf_count", n_sent - n0, 6);

    // busy never rises: timeout after 3 WAIT_HI cycles, next byte follows
    busy_len = 0;
    n0 = n_sent;
    tick();
    cpu_wr = 1'b1;
    cpu_data = 8'hB1;
    exp_q.push_back(8'hB1);
    tick();
    cpu_data = 8'hB2;
    exp_q.push_back(8'hB2);
    tick();
    cpu_wr = 1'b0;
    wait_idle(100, "tmo_idle");
    chk("tmo_count", n_sent - n0, 2);
    if (en_times.size() >= 2)
      chk("tmo_gap", en_times[en_times.size()-1] - en_times[en_times.size()-2], 5);

    // reset during WAIT_LO with bytes queued and overflow set
    busy_len = 20;
    n0 = n_sent;
    tick();
    cpu_wr = 1'b1;
    cpu_data = 8'hC1;
    exp_q.push_back(8'hC1);
    for (int i = 2; i <= 6; i++) begin
      tick();
      cpu_data = 8'hC0 + 8'(i);
    end
    tick();
    cpu_wr = 1'b0;
    chk("mid_ovf", overflow, 1'b1);
    chk("mid_arb_busy", arb_busy, 1'b1);
    chk("mid_full", fifo_full, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_empty", fifo_empty, 1'b1);
    chk("mid_rst_full", fifo_full, 1'b0);
    chk("mid_rst_en", uart_tx_en, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_arb_busy", arb_busy, 1'b0);
    rst = 1'b0;
    repeat (30) tick();
    chk("mid_rst_count", n_sent - n0, 1);

    // continuous demand on both sides: strict alternation starting with CPU
    busy_len = 2;
    n0 = n_sent;
    tick();
    cpu_wr = 1'b1;
    cpu_data = 8'hA0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hA0 + 8'(i));
      exp_q.push_back(8'h70 + 8'(i));
    end
    tick();
    cpu_data = 8'hA1;
    for (int i = 0; i < 4; i++) tq.push_back(8'h70 + 8'(i));
    tick();
    cpu_data = 8'hA2;
    tick();
    cpu_data = 8'hA3;
    tick();
    cpu_wr = 1'b0;
    wait_idle(300, "alt_idle");
    chk("alt_count", n_sent - n0, 8);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
